lut_mux_seq: RTL and testbench

LUT_MUX_SEQ -- requirements
Module: lut_mux_seq

---
 rtl/lut_mux_seq.sv | 125 ++++++++++++
 tb/tb_lut_mux_seq.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_mux_seq.sv
// Serially loaded 2**SEL_W-entry LUT mux: each entry decodes to 0, 1, d or ~d.
// Latency: 1 cycle from an accepted evaluation to out_valid/y.
// Backpressure: in_ready drops while a result is held and out_ready is low, or whenever not in RUN.
module lut_mux_seq #(
    parameter int   SEL_W   = 3,
    parameter logic DIS_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic             d,
    input  logic             sn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y
);

    // Two bits per entry, so the table and its bit counter are one bit wider than sel.
    localparam int                TBL_BITS = 2 ** (SEL_W + 1);
    localparam int                CNT_W    = SEL_W + 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(TBL_BITS - 1);

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TBL_BITS-1:0] tbl;
    logic [CNT_W-1:0]    cnt;
    logic                bit_acc;
    logic                last_acc;
    logic                xfer;
    logic [1:0]          code;
    logic                result;

    // A config bit is only taken in LOAD, and never in a cfg_start cycle (that cycle restarts the count).
    always_comb begin
        bit_acc  = (state == LOAD) && cfg_valid && !cfg_start;
        last_acc = bit_acc && (cnt == LAST_IDX);
    end

    // Next-state logic: cfg_start always (re)enters LOAD; the final bit moves LOAD to RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            UNCFG: if (cfg_start) state_nxt = LOAD;
            LOAD: begin
                if (cfg_start)     state_nxt = LOAD;
                else if (last_acc) state_nxt = RUN;
            end
            RUN:   if (cfg_start) state_nxt = LOAD;
            default:              state_nxt = UNCFG;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= UNCFG;
        else        state <= state_nxt;
    end

    // Bit counter: restarts on cfg_start, wraps to 0 after the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cfg_start) begin
            cnt <= '0;
        end else if (bit_acc) begin
            cnt <= last_acc ? '0 : cnt + 1'b1;
        end
    end

    // Table storage: the k-th accepted bit lands at index k, overwriting any earlier load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       tbl      <= '0;
        else if (bit_acc) tbl[cnt] <= cfg_bit;
    end

    // Completion pulse, lands in the first RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_done <= 1'b0;
        else        cfg_done <= last_acc;
    end

    // Ready only in RUN, and only if the output slot is empty or draining this cycle.
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;

    // Entry decode: 00 -> 0, 01 -> 1, 10 -> d, 11 -> ~d; a high strobe forces DIS_VAL.
    always_comb begin
        code   = {tbl[{sel, 1'b1}], tbl[{sel, 1'b0}]};
        result = 1'b0;
        case (code)
            2'b00:   result = 1'b0;
            2'b01:   result = 1'b1;
            2'b10:   result = d;
            2'b11:   result = ~d;
            default: result = 1'b0;
        endcase
        if (sn) result = DIS_VAL;
    end

    // Output register: capture on transfer, hold while stalled, clear when drained with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= 1'b0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            y         <= result;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lut_mux_seq.sv
// Directed bench for lut_mux_seq (default parameters: SEL_W=3, DIS_VAL=1).
// Inputs change 1 ns after the rising edge; outputs are sampled 1-2 ns after the edge.
// Each task performs its own inline comparisons against hand-computed values.
module tb_lut_mux_seq;

    logic       clk;
    logic       rst_n;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_bit;
    logic       cfg_done;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] sel;
    logic       d;
    logic       sn;
    logic       out_valid;
    logic       out_ready;
    logic       y;

    int tests_run;
    int tests_failed;

    // Table of entries 0..7 = 00,11,10,10,10,00,01,00 as serial bits 0..15.
    logic [15:0] tbl_a;
    // Every entry 01 (constant 1).
    logic [15:0] tbl_ones;
    int          exp_y [16];

    lut_mux_seq #(.SEL_W(3), .DIS_VAL(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_done  (cfg_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .d         (d),
        .sn        (sn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full load sequence: start pulse, all 16 bits, then one idle cycle; reports cfg_done pulses seen.
    task automatic do_load(input logic [15:0] bits, output int dn);
        dn        = 0;
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        tick();
        if (cfg_done) dn++;
        cfg_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = bits[k];
            tick();
            if (cfg_done) dn++;
        end
        cfg_valid = 1'b0;
        tick();
        if (cfg_done) dn++;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (2) tick();
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (y !== 1'b0) begin tests_failed++; $display("FAIL reset_y: got %b expected 0", y); end
        tests_run++;
        if (cfg_done !== 1'b0) begin tests_failed++; $display("FAIL reset_cfg_done: got %b expected 0", cfg_done); end
        rst_n = 1'b1;
        tick();
        tick();
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL unconfigured_in_ready: got %b expected 0", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_load();
        int dn;
        int done_at;
        dn        = 0;
        done_at   = -1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = tbl_a[k];
            if (k == 7) begin
                tests_run++;
                if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL load_in_ready_midload: got %b expected 0", in_ready); end
            end
            tick();
            if (cfg_done) begin dn++; done_at = k; end
        end
        cfg_valid = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL load_in_ready_after: got %b expected 1", in_ready); end
        tick();
        if (cfg_done) dn++;
        tests_run++;
        if (dn !== 1) begin tests_failed++; $display("FAIL load_done_count: got %0d expected 1", dn); end
        tests_run++;
        if (done_at !== 15) begin tests_failed++; $display("FAIL load_done_timing: got bit %0d expected 15", done_at); end
    endtask

    task automatic test_back_to_back();
        exp_y     = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 0};
        sn        = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel = 3'(i % 8);
            d   = (i >= 8);
            #1;
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || y !== 1'(exp_y[i])) begin
                tests_failed++;
                $display("FAIL b2b_y[%0d]: got y=%b vld=%b expected y=%0d vld=1", i, y, out_valid, exp_y[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_disable();
        sn        = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = 3'd3;
        d         = 1'b1;
        tick();
        tests_run++;
        if (y !== 1'b1 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL disable_sel3: got y=%b vld=%b expected y=1 vld=1", y, out_valid); end
        sel = 3'd0;
        d   = 1'b0;
        tick();
        tests_run++;
        if (y !== 1'b1) begin tests_failed++; $display("FAIL disable_sel0: got y=%b expected 1", y); end
        in_valid = 1'b0;
        sn       = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int nx;
        nx        = 0;
        sn        = 1'b0;
        in_valid  = 1'b1;
        sel       = 3'd1;
        d         = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        sel       = 3'd0;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests_run++;
            if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", c, in_ready); end
            if (in_valid && in_ready) nx++;
            tick();
            tests_run++;
            if (y !== 1'b1 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_hold[%0d]: got y=%b vld=%b expected y=1 vld=1", c, y, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        if (in_valid && in_ready) nx++;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (y !== 1'b0 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_release: got y=%b vld=%b expected y=0 vld=1", y, out_valid); end
        for (int c = 0; c < 3; c++) begin
            #1;
            if (in_valid && in_ready) nx++;
            tick();
        end
        tests_run++;
        if (nx !== 1) begin tests_failed++; $display("FAIL stall_xfer_count: got %0d expected 1", nx); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_empty: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_reload_pending();
        int nx;
        nx        = 0;
        sn        = 1'b0;
        in_valid  = 1'b1;
        sel       = 3'd1;
        d         = 1'b0;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = tbl_ones[k];
            out_ready = (k == 10);
            in_valid  = 1'b1;
            sel       = 3'(k % 8);
            d         = 1'b0;
            #1;
            if (k == 5) begin
                tests_run++;
                if (y !== 1'b1 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL reload_pending_hold: got y=%b vld=%b expected y=1 vld=1", y, out_valid); end
            end
            if (k == 10) begin
                tests_run++;
                if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reload_in_ready_load: got %b expected 0", in_ready); end
            end
            if (k == 11) begin
                tests_run++;
                if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reload_drained: got out_valid=%b expected 0", out_valid); end
            end
            if (in_valid && in_ready) nx++;
            tick();
        end
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests_run++;
        if (nx !== 0) begin tests_failed++; $display("FAIL reload_no_xfer: got %0d transfers expected 0", nx); end
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            sel      = 3'(i % 8);
            d        = (i >= 8);
            tick();
            tests_run++;
            if (y !== 1'b1 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL reload_ones[%0d]: got y=%b vld=%b expected y=1 vld=1", i, y, out_valid); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_start_with_xfer();
        int dn;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = 3'd0;
        d         = 1'b0;
        cfg_start = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL startx_in_ready: got %b expected 1", in_ready); end
        tick();
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        tests_run++;
        if (y !== 1'b1 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL startx_old_table: got y=%b vld=%b expected y=1 vld=1", y, out_valid); end
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL startx_in_load: got in_ready=%b expected 0", in_ready); end
        do_load(tbl_a, dn);
        tests_run++;
        if (dn !== 1) begin tests_failed++; $display("FAIL startx_done_count: got %0d expected 1", dn); end
        in_valid = 1'b1;
        sel      = 3'd0;
        d        = 1'b0;
        tick();
        tests_run++;
        if (y !== 1'b0) begin tests_failed++; $display("FAIL startx_new_table: got y=%b expected 0", y); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midload();
        int rdy_seen;
        int dn;
        rdy_seen  = 0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = tbl_ones[k];
            tick();
        end
        cfg_valid = 1'b0;
        rst_n     = 1'b0;
        #2;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || cfg_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midload_reset: got rdy=%b vld=%b done=%b expected 0/0/0", in_ready, out_valid, cfg_done);
        end
        tick();
        rst_n     = 1'b1;
        tick();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sn        = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = tbl_ones[k];
            #1;
            if (in_ready) rdy_seen++;
            tick();
        end
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        tests_run++;
        if (rdy_seen !== 0) begin tests_failed++; $display("FAIL midload_no_ready: got %0d ready cycles expected 0", rdy_seen); end
        do_load(tbl_ones, dn);
        tests_run++;
        if (in_ready !== 1'b1 || dn !== 1) begin tests_failed++; $display("FAIL midload_reload: got rdy=%b done_count=%0d expected rdy=1 done_count=1", in_ready, dn); end
    endtask

    task automatic test_restart_load();
        int dn;
        int done_at;
        dn        = 0;
        done_at   = -1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            tick();
        end
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = tbl_ones[k];
            tick();
            if (cfg_done) begin dn++; done_at = k; end
        end
        cfg_valid = 1'b0;
        tick();
        if (cfg_done) dn++;
        tests_run++;
        if (dn !== 1 || done_at !== 15) begin tests_failed++; $display("FAIL restart_done: got count=%0d at bit %0d expected count=1 at bit 15", dn, done_at); end
        out_ready = 1'b1;
        sn        = 1'b0;
        in_valid  = 1'b1;
        sel       = 3'd0;
        d         = 1'b0;
        tick();
        tests_run++;
        if (y !== 1'b1) begin tests_failed++; $display("FAIL restart_sel0: got y=%b expected 1", y); end
        sel = 3'd2;
        tick();
        tests_run++;
        if (y !== 1'b1) begin tests_failed++; $display("FAIL restart_sel2: got y=%b expected 1", y); end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        tbl_a        = 16'b0001_0010_1010_1100;
        tbl_ones     = 16'h5555;
        rst_n        = 1'b0;
        cfg_start    = 1'b0;
        cfg_valid    = 1'b0;
        cfg_bit      = 1'b0;
        in_valid     = 1'b0;
        sel          = 3'd0;
        d            = 1'b0;
        sn           = 1'b0;
        out_ready    = 1'b0;

        test_reset();
        test_load();
        test_back_to_back();
        test_disable();
        test_backpressure();
        test_reload_pending();
        test_start_with_xfer();
        test_reset_midload();
        test_restart_load();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
